alu_issue_arbiter: RTL and testbench

- Shares the single-cycle integer ALU among NUM_RS reservation stations in the out-of-order core.
- Each cycle it picks at most one ready instruction round-robin and registers it into the ALU input stage.
- It captures the ALU result with its issuing tag and buffers it in a small result FIFO until the common data bus (CDB) grants a broadcast slot.
- Issue is credit-gated so that a result is never dropped.

---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/alu_issue_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and issue payload types for the integer execution cluster.
package riscv_pkg;

  localparam int unsigned OPCODE_W    = 7;
  localparam int unsigned FUNCT3_W    = 6;
  localparam int unsigned FUNCT7_W    = 7;
  localparam int unsigned IMM5_W      = 5;
  localparam int unsigned IMM_FUNCT_W = 7;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_W   = 4;

  localparam logic [6:0] OPC_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_U_TYPE       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC        = 7'b0010111;
  localparam logic [6:0] OPC_B_TYPE       = 7'b1100011;
  localparam logic [6:0] OPC_JAL          = 7'b1101111;
  localparam logic [6:0] OPC_LOAD         = 7'b0000011;
  localparam logic [6:0] OPC_STORE        = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [OPCODE_W-1:0]    opcode;
    logic [FUNCT3_W-1:0]    funct3;
    logic [FUNCT7_W-1:0]    funct7;
    logic [IMM5_W-1:0]      imm5;
    logic [IMM_FUNCT_W-1:0] imm_funct;
  } issue_ctrl_t;

  // Full payload for the default core configuration (XLEN operands, ROB tag).
  typedef struct packed {
    issue_ctrl_t           ctrl;
    logic [XLEN-1:0]       src1;
    logic [XLEN-1:0]       src2;
    logic [ROB_TAG_W-1:0]  tag;
  } issue_payload_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin arbiter; the pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int unsigned   idx;

  // Search upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of reservation-station instructions into the shared ALU, with a
// credit-gated result FIFO holding results until the CDB grants a broadcast slot.
module alu_issue_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned NUM_RS     = 4,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [NUM_RS-1:0]            req_valid,
  output logic [NUM_RS-1:0]            req_ready,
  input  logic [NUM_RS*7-1:0]          req_opcode,
  input  logic [NUM_RS*6-1:0]          req_funct3,
  input  logic [NUM_RS*7-1:0]          req_funct7,
  input  logic [NUM_RS*5-1:0]          req_imm5,
  input  logic [NUM_RS*7-1:0]          req_imm_funct,
  input  logic [NUM_RS*DATA_WIDTH-1:0] req_src1,
  input  logic [NUM_RS*DATA_WIDTH-1:0] req_src2,
  input  logic [NUM_RS*ID_WIDTH-1:0]   req_tag,
  output logic [6:0]                   alu_opcode,
  output logic [5:0]                   alu_funct3,
  output logic [6:0]                   alu_funct7,
  output logic [4:0]                   alu_reduced_imm,
  output logic [6:0]                   alu_imm_funct,
  output logic [DATA_WIDTH-1:0]        alu_src1,
  output logic [DATA_WIDTH-1:0]        alu_src2,
  output logic [ID_WIDTH-1:0]          alu_tag,
  output logic                         alu_valid,
  input  logic [DATA_WIDTH-1:0]        alu_sum,
  output logic                         cdb_req,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [ID_WIDTH-1:0]          cdb_tag,
  input  logic                         cdb_grant
);

  localparam int unsigned PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         grant_idx;
  int unsigned           sel;
  logic                  issue_en;
  logic                  handshake;
  logic                  push;
  logic                  pop;

  issue_ctrl_t           alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0] alu_src1_q, alu_src1_d;
  logic [DATA_WIDTH-1:0] alu_src2_q, alu_src2_d;
  logic [ID_WIDTH-1:0]   alu_tag_q, alu_tag_d;
  logic                  alu_valid_q, alu_valid_d;

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
  logic [ID_WIDTH-1:0]   mem_tag_q  [DEPTH];
  logic [ID_WIDTH-1:0]   mem_tag_d  [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit check: FIFO slots left after the ALU-stage result lands, plus this cycle's pop.
  assign pop       = (count_q != '0) && cdb_grant;
  assign issue_en  = resetn && !flush &&
                     ((32'(count_q) + 32'(alu_valid_q)) < (DEPTH + 32'(pop)));
  assign handshake = |req_ready;
  assign push      = alu_valid_q && !flush;
  assign sel       = 32'(grant_idx);

  rr_arbiter #(.N(NUM_RS)) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .en        (issue_en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    alu_ctrl_d  = alu_ctrl_q;
    alu_src1_d  = alu_src1_q;
    alu_src2_d  = alu_src2_q;
    alu_tag_d   = alu_tag_q;
    alu_valid_d = 1'b0;
    mem_data_d  = mem_data_q;
    mem_tag_d   = mem_tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (handshake) begin
      alu_ctrl_d.opcode    = req_opcode[7*sel +: 7];
      alu_ctrl_d.funct3    = req_funct3[6*sel +: 6];
      alu_ctrl_d.funct7    = req_funct7[7*sel +: 7];
      alu_ctrl_d.imm5      = req_imm5[5*sel +: 5];
      alu_ctrl_d.imm_funct = req_imm_funct[7*sel +: 7];
      alu_src1_d           = req_src1[DATA_WIDTH*sel +: DATA_WIDTH];
      alu_src2_d           = req_src2[DATA_WIDTH*sel +: DATA_WIDTH];
      alu_tag_d            = req_tag[ID_WIDTH*sel +: ID_WIDTH];
      alu_valid_d          = 1'b1;
    end

    // Flush drops both queued results and the one currently in the ALU stage.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_data_d[wr_ptr_q] = alu_sum;
        mem_tag_d[wr_ptr_q]  = alu_tag_q;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_ctrl_q  <= '0;
      alu_src1_q  <= '0;
      alu_src2_q  <= '0;
      alu_tag_q   <= '0;
      alu_valid_q <= 1'b0;
      mem_data_q  <= '{default: '0};
      mem_tag_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src1_q  <= alu_src1_d;
      alu_src2_q  <= alu_src2_d;
      alu_tag_q   <= alu_tag_d;
      alu_valid_q <= alu_valid_d;
      mem_data_q  <= mem_data_d;
      mem_tag_q   <= mem_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign alu_opcode      = alu_ctrl_q.opcode;
  assign alu_funct3      = alu_ctrl_q.funct3;
  assign alu_funct7      = alu_ctrl_q.funct7;
  assign alu_reduced_imm = alu_ctrl_q.imm5;
  assign alu_imm_funct   = alu_ctrl_q.imm_funct;
  assign alu_src1        = alu_src1_q;
  assign alu_src2        = alu_src2_q;
  assign alu_tag         = alu_tag_q;
  assign alu_valid       = alu_valid_q;
  assign cdb_req         = (count_q != '0);
  assign cdb_data        = mem_data_q[rd_ptr_q];
  assign cdb_tag         = mem_tag_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ADD/SUB ALU on the issue stage.
module tb_alu_issue_arbiter;
  import riscv_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned NR    = 4;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              resetn, flush, cdb_grant;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*7-1:0]   req_opcode, req_funct7, req_imm_funct;
  logic [NR*6-1:0]   req_funct3;
  logic [NR*5-1:0]   req_imm5;
  logic [NR*DW-1:0]  req_src1, req_src2;
  logic [NR*IW-1:0]  req_tag;
  logic [6:0]        alu_opcode, alu_funct7, alu_imm_funct;
  logic [5:0]        alu_funct3;
  logic [4:0]        alu_reduced_imm;
  logic [DW-1:0]     alu_src1, alu_src2, alu_sum, cdb_data;
  logic [IW-1:0]     alu_tag, cdb_tag;
  logic              alu_valid, cdb_req;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural single-cycle ALU: R-type with SUB funct7 subtracts, everything else adds.
  always_comb begin
    if (alu_opcode == OPC_R_TYPE && alu_funct7 == FUNCT7_SUB) alu_sum = alu_src1 - alu_src2;
    else                                                      alu_sum = alu_src1 + alu_src2;
  end

  alu_issue_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_RS(NR), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_imm5(req_imm5), .req_imm_funct(req_imm_funct),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_reduced_imm(alu_reduced_imm), .alu_imm_funct(alu_imm_funct),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_tag(alu_tag), .alu_valid(alu_valid),
    .alu_sum(alu_sum),
    .cdb_req(cdb_req), .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_grant(cdb_grant)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rs(input int i, input logic [6:0] f7, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [IW-1:0] tag);
    req_opcode[7*i +: 7]   = OPC_R_TYPE;
    req_funct3[6*i +: 6]   = 6'(F3_ADD_SUB);
    req_funct7[7*i +: 7]   = f7;
    req_src1[DW*i +: DW]   = a;
    req_src2[DW*i +: DW]   = b;
    req_tag[IW*i +: IW]    = tag;
  endtask

  // Credit gating must never let a push land on a full FIFO without a matching pop.
  always @(negedge clk) begin
    if (resetn === 1'b1 && dut.push && !dut.pop && 32'(dut.count_q) == DEPTH) begin
      n_err++;
      $error("FAIL fifo_overflow: observed push with count %0d, required no push when full",
             dut.count_q);
    end
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; cdb_grant = 1'b0; req_valid = '0;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0; req_imm5 = '0; req_imm_funct = '0;
    req_src1 = '0; req_src2 = '0; req_tag = '0;
    set_rs(0, FUNCT7_BASE, 32'd1,  32'd2,  4'd0);
    set_rs(1, FUNCT7_BASE, 32'd5,  32'd7,  4'd3);
    set_rs(2, FUNCT7_BASE, 32'd10, 32'd20, 4'd5);
    set_rs(3, FUNCT7_BASE, 32'd8,  32'd9,  4'd7);
    tick(); tick();

    // Reset state
    settle();
    chk("rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst_cdb_req",   64'(cdb_req),   64'd0);
    chk("rst_cdb_data",  64'(cdb_data),  64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_alu_src1",  64'(alu_src1),  64'd0);
    chk("rst_alu_tag",   64'(alu_tag),   64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    resetn = 1'b1;

    // Idle: no requests for five cycles
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("idle_ready", 64'(req_ready), 64'd0);
      chk("idle_alu_valid", 64'(alu_valid), 64'd0);
      chk("idle_cdb_req", 64'(cdb_req), 64'd0);
      tick();
    end

    // All RS ready, CDB always granting: rotation and 2-cycle latency
    req_valid = 4'b1111; cdb_grant = 1'b1;
    settle();
    chk("rot0_ready", 64'(req_ready), 64'b0001);
    tick(); settle();
    chk("rot1_ready", 64'(req_ready), 64'b0010);
    chk("rot1_alu_valid", 64'(alu_valid), 64'd1);
    chk("rot1_alu_src1", 64'(alu_src1), 64'd1);
    chk("rot1_cdb_req", 64'(cdb_req), 64'd0);
    tick(); settle();
    chk("rot2_ready", 64'(req_ready), 64'b0100);
    chk("rot2_alu_tag", 64'(alu_tag), 64'd3);
    chk("rot2_cdb_req", 64'(cdb_req), 64'd1);
    chk("rot2_cdb_data", 64'(cdb_data), 64'd3);
    chk("rot2_cdb_tag", 64'(cdb_tag), 64'd0);
    tick(); settle();
    chk("rot3_ready", 64'(req_ready), 64'b1000);
    chk("add_cdb_req", 64'(cdb_req), 64'd1);
    chk("add_cdb_data", 64'(cdb_data), 64'd12);
    chk("add_cdb_tag", 64'(cdb_tag), 64'd3);
    chk("rot3_alu_src1", 64'(alu_src1), 64'd10);
    chk("rot3_alu_opcode", 64'(alu_opcode), 64'(OPC_R_TYPE));
    tick(); settle();
    chk("rot4_ready_wrap", 64'(req_ready), 64'b0001);
    chk("rot4_cdb_data", 64'(cdb_data), 64'd30);
    chk("rot4_cdb_tag", 64'(cdb_tag), 64'd5);
    tick();
    req_valid = '0;
    settle();
    chk("drain_ready", 64'(req_ready), 64'd0);
    chk("drain_cdb_data", 64'(cdb_data), 64'd17);
    chk("drain_alu_tag", 64'(alu_tag), 64'd0);
    tick(); settle();
    chk("drain_alu_valid", 64'(alu_valid), 64'd0);
    chk("drain_alu_tag_hold", 64'(alu_tag), 64'd0);
    chk("drain_cdb_data2", 64'(cdb_data), 64'd3);
    tick(); settle();
    chk("drain_empty", 64'(cdb_req), 64'd0);

    // CDB stalled: exactly DEPTH handshakes, then backpressure
    cdb_grant = 1'b0;
    set_rs(0, FUNCT7_SUB, 32'd10, 32'd3, 4'd1);
    req_valid = 4'b0001;
    settle();
    chk("stall_hs1_ready", 64'(req_ready), 64'b0001);
    tick();
    set_rs(0, FUNCT7_SUB, 32'd20, 32'd5, 4'd2);
    settle();
    chk("stall_hs2_ready", 64'(req_ready), 64'b0001);
    chk("stall_alu_src1", 64'(alu_src1), 64'd10);
    chk("stall_alu_funct7", 64'(alu_funct7), 64'(FUNCT7_SUB));
    tick(); settle();
    chk("stall_full_ready", 64'(req_ready), 64'd0);
    chk("stall_cdb_data", 64'(cdb_data), 64'd7);
    chk("stall_cdb_tag", 64'(cdb_tag), 64'd1);
    set_rs(0, FUNCT7_BASE, 32'd1, 32'd1, 4'd9);
    tick(); settle();
    chk("stall_hold_ready", 64'(req_ready), 64'd0);
    chk("stall_hold_alu_valid", 64'(alu_valid), 64'd0);
    chk("stall_hold_alu_src1", 64'(alu_src1), 64'd20);
    tick(); settle();
    chk("stall_hold2_ready", 64'(req_ready), 64'd0);
    cdb_grant = 1'b1;
    settle();
    chk("resume_ready", 64'(req_ready), 64'b0001);
    chk("resume_cdb_data", 64'(cdb_data), 64'd7);
    tick(); settle();
    chk("resume_cdb_data2", 64'(cdb_data), 64'd15);
    chk("resume_cdb_tag2", 64'(cdb_tag), 64'd2);
    chk("resume_alu_tag", 64'(alu_tag), 64'd9);
    req_valid = '0;
    tick(); settle();
    chk("resume_cdb_data3", 64'(cdb_data), 64'd2);
    chk("resume_cdb_tag3", 64'(cdb_tag), 64'd9);
    tick(); settle();
    chk("resume_empty", 64'(cdb_req), 64'd0);

    // Single requester RS2: first from ptr=1, then from ptr=3 with wrap
    req_valid = 4'b0100;
    settle();
    chk("rs2_ready_a", 64'(req_ready), 64'b0100);
    tick(); settle();
    chk("rs2_ready_wrap", 64'(req_ready), 64'b0100);
    chk("grant_while_empty", 64'(cdb_req), 64'd0);
    tick();

    // Flush with one queued result and one in the ALU stage
    req_valid = 4'b1111; cdb_grant = 1'b0; flush = 1'b1;
    settle();
    chk("flush_ready", 64'(req_ready), 64'd0);
    chk("flush_pre_cdb_req", 64'(cdb_req), 64'd1);
    chk("flush_pre_cdb_data", 64'(cdb_data), 64'd30);
    chk("flush_pre_alu_valid", 64'(alu_valid), 64'd1);
    tick();
    flush = 1'b0; req_valid = '0; cdb_grant = 1'b1;
    settle();
    chk("flush_cdb_req", 64'(cdb_req), 64'd0);
    chk("flush_alu_valid", 64'(alu_valid), 64'd0);
    tick(); settle();
    chk("flush_no_ghost", 64'(cdb_req), 64'd0);
    req_valid = 4'b1111;
    settle();
    chk("flush_ptr_kept", 64'(req_ready), 64'b1000);
    tick(); settle();
    chk("post_flush_ready", 64'(req_ready), 64'b0001);
    chk("post_flush_alu_tag", 64'(alu_tag), 64'd7);
    tick(); settle();
    chk("pre_rst_alu_tag", 64'(alu_tag), 64'd9);
    chk("pre_rst_cdb_data", 64'(cdb_data), 64'd17);
    chk("pre_rst_ready", 64'(req_ready), 64'b0010);

    // One-cycle reset mid-stream
    resetn = 1'b0;
    settle();
    chk("in_rst_ready", 64'(req_ready), 64'd0);
    tick();
    resetn = 1'b1;
    settle();
    chk("mid_rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("mid_rst_cdb_req", 64'(cdb_req), 64'd0);
    chk("mid_rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("mid_rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("mid_rst_alu_src1", 64'(alu_src1), 64'd0);
    chk("mid_rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("mid_rst_alu_funct7", 64'(alu_funct7), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'b0001);
    tick(); settle();
    chk("restart_alu_valid", 64'(alu_valid), 64'd1);
    chk("restart_alu_tag", 64'(alu_tag), 64'd9);
    chk("restart_alu_src1", 64'(alu_src1), 64'd1);
    chk("restart_ready", 64'(req_ready), 64'b0010);
    tick(); settle();
    chk("restart_cdb_data", 64'(cdb_data), 64'd2);
    chk("restart_cdb_tag", 64'(cdb_tag), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
